// File: rtl/stt8_gfx_pkg.sv
// Shared definitions for the entity path of the graphics pipeline:
// entity word geometry, slot numbering, and the loader FSM state type.
package stt8_gfx_pkg;

   localparam int ENTITY_W  = 14;
   localparam int NUM_SLOTS = 9;
   localparam int BANK_W    = ENTITY_W * NUM_SLOTS;

   // id nibble F marks a slot as unused by the frame buffer
   localparam logic [ENTITY_W-1:0] ENTITY_UNUSED = 14'h3C00;

   // Slot field carried in the upper nibble of a packet header
   typedef enum logic [3:0] {
      SLOT_1   = 4'd0,
      SLOT_2   = 4'd1,
      SLOT_3   = 4'd2,
      SLOT_4   = 4'd3,
      SLOT_5   = 4'd4,
      SLOT_6   = 4'd5,
      SLOT_7   = 4'd6,
      SLOT_8   = 4'd7,
      SLOT_9   = 4'd8,
      CLR_SLOT = 4'hF
   } slot_e;

   // Packet parser states
   typedef enum logic [1:0] {
      ST_HDR = 2'd0,
      ST_ORI = 2'd1,
      ST_LOC = 2'd2,
      ST_CLR = 2'd3
   } loader_state_e;

   // Entity word layout: {id, orient, tile}
   function automatic logic [ENTITY_W-1:0] pack_entity(
      input logic [3:0] id,
      input logic [1:0] orient,
      input logic [7:0] tile
   );
      return {id, orient, tile};
   endfunction

endpackage

// File: rtl/entity_bank.sv
// Double-buffered entity storage: a shadow bank written by the parser and
// an active bank seen by the frame buffer. A commit copies shadow to active
// only when something changed since the previous commit.
module entity_bank
   import stt8_gfx_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [3:0]          wr_slot,
   input  logic [ENTITY_W-1:0] wr_data,
   input  logic                clr_en,
   input  logic [3:0]          clr_slot,
   input  logic                commit_req,
   output logic [BANK_W-1:0]   active_bank,
   output logic                committed
);

   logic dirty_reg;
   logic committed_reg;
   logic commit_fire;

   // A commit request is ignored when the shadow matches the active bank
   assign commit_fire = commit_req && dirty_reg;
   assign committed   = committed_reg;

   // Dirty tracking: a write or clear step in the commit cycle keeps dirty set,
   // because the commit copies the pre-write shadow contents
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dirty_reg     <= 1'b0;
         committed_reg <= 1'b0;
      end else begin
         committed_reg <= commit_fire;
         if (wr_en || clr_en)
            dirty_reg <= 1'b1;
         else if (commit_fire)
            dirty_reg <= 1'b0;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         localparam logic [3:0] SLOT_IDX = 4'(gi);

         logic [ENTITY_W-1:0] shadow_reg;
         logic [ENTITY_W-1:0] active_reg;

         // Per-slot shadow update (clear sweep) and shadow-to-active copy
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               shadow_reg <= ENTITY_UNUSED;
               active_reg <= ENTITY_UNUSED;
            end else begin
               if (clr_en && (clr_slot == SLOT_IDX))
                  shadow_reg <= ENTITY_UNUSED;
               else if (wr_en && (wr_slot == SLOT_IDX))
                  shadow_reg <= wr_data;
               if (commit_fire)
                  active_reg <= shadow_reg;
            end
         end

         assign active_bank[gi*ENTITY_W +: ENTITY_W] = active_reg;
      end
   endgenerate

endmodule

// File: rtl/entity_loader.sv
// Byte-serial entity update front end. Parses {header, orient, tile}
// packets into the shadow bank and publishes the bank to the frame buffer
// at each vertical-blank entry, so a frame always sees a consistent scene.
module entity_loader
   import stt8_gfx_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          data_in,
   input  logic                data_valid,
   input  logic                data_sof,
   output logic                data_ready,
   input  logic                vblank,
   output logic [ENTITY_W-1:0] entity_1,
   output logic [ENTITY_W-1:0] entity_2,
   output logic [ENTITY_W-1:0] entity_3,
   output logic [ENTITY_W-1:0] entity_4,
   output logic [ENTITY_W-1:0] entity_5,
   output logic [ENTITY_W-1:0] entity_6,
   output logic [ENTITY_W-1:0] entity_7,
   output logic [ENTITY_W-1:0] entity_8_Flip,
   output logic [ENTITY_W-1:0] entity_9_Flip,
   output logic                frame_commit,
   output logic                slot_err
);

   localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);

   loader_state_e state_reg;
   loader_state_e state_next;

   logic [3:0] slot_reg;
   logic [3:0] id_reg;
   logic [1:0] orient_reg;
   logic       drop_reg;
   logic [3:0] clr_cnt_reg;
   logic       slot_err_reg;
   logic       ready_reg;
   logic       vblank_reg;
   logic       vblank_rise_reg;

   logic       accept;
   logic [3:0] hdr_slot;
   logic       hdr_is_clr;
   logic       hdr_bad;
   logic       hdr_take;

   logic       wr_en;
   logic       clr_en;
   logic       load_hdr;
   logic       load_orient;
   logic       clr_start;

   logic [BANK_W-1:0] active_bank;

   assign accept     = data_valid && ready_reg;
   assign hdr_slot   = data_in[7:4];
   assign hdr_is_clr = (hdr_slot == CLR_SLOT);
   assign hdr_bad    = (hdr_slot > LAST_SLOT) && !hdr_is_clr;
   // Any accepted sof byte is a header, even mid-packet (resync)
   assign hdr_take   = accept && data_sof;

   // Parser state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_reg <= ST_HDR;
      else
         state_reg <= state_next;
   end

   // Parser next-state: headers restart the packet from any accepting state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_HDR: begin
            if (hdr_take)
               state_next = hdr_is_clr ? ST_CLR : ST_ORI;
         end
         ST_ORI: begin
            if (hdr_take)
               state_next = hdr_is_clr ? ST_CLR : ST_ORI;
            else if (accept)
               state_next = ST_LOC;
         end
         ST_LOC: begin
            if (hdr_take)
               state_next = hdr_is_clr ? ST_CLR : ST_ORI;
            else if (accept)
               state_next = ST_HDR;
         end
         ST_CLR: begin
            if (clr_cnt_reg == LAST_SLOT)
               state_next = ST_HDR;
         end
         default: state_next = ST_HDR;
      endcase
   end

   // Parser outputs: field loads, shadow write and clear sweep strobes
   always_comb begin
      wr_en       = 1'b0;
      clr_en      = 1'b0;
      load_hdr    = 1'b0;
      load_orient = 1'b0;
      clr_start   = 1'b0;
      if (hdr_take) begin
         load_hdr  = !hdr_is_clr;
         clr_start = hdr_is_clr;
      end else if (accept) begin
         case (state_reg)
            ST_ORI:  load_orient = 1'b1;
            ST_LOC:  wr_en       = !drop_reg;
            default: ;
         endcase
      end
      if (state_reg == ST_CLR)
         clr_en = 1'b1;
   end

   // Packet field capture, sticky slot error and clear sweep counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_reg     <= 4'd0;
         id_reg       <= 4'd0;
         orient_reg   <= 2'd0;
         drop_reg     <= 1'b0;
         clr_cnt_reg  <= 4'd0;
         slot_err_reg <= 1'b0;
      end else begin
         if (load_hdr) begin
            slot_reg <= hdr_slot;
            id_reg   <= data_in[3:0];
            drop_reg <= hdr_bad;
         end
         if (hdr_take && hdr_bad)
            slot_err_reg <= 1'b1;
         if (load_orient)
            orient_reg <= data_in[7:6];
         if (clr_start)
            clr_cnt_reg <= 4'd0;
         else if (clr_en)
            clr_cnt_reg <= clr_cnt_reg + 4'd1;
      end
   end

   // Registered ready: low throughout the clear sweep and while in reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         ready_reg <= 1'b0;
      else
         ready_reg <= (state_next != ST_CLR);
   end

   // vblank rise detector; history starts high so leaving reset inside
   // blanking does not look like a new blanking interval
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vblank_reg      <= 1'b1;
         vblank_rise_reg <= 1'b0;
      end else begin
         vblank_reg      <= vblank;
         vblank_rise_reg <= vblank && !vblank_reg;
      end
   end

   entity_bank u_bank (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_slot     (slot_reg),
      .wr_data     (pack_entity(id_reg, orient_reg, data_in)),
      .clr_en      (clr_en),
      .clr_slot    (clr_cnt_reg),
      .commit_req  (vblank_rise_reg),
      .active_bank (active_bank),
      .committed   (frame_commit)
   );

   assign data_ready    = ready_reg;
   assign slot_err      = slot_err_reg;
   assign entity_1      = active_bank[0*ENTITY_W +: ENTITY_W];
   assign entity_2      = active_bank[1*ENTITY_W +: ENTITY_W];
   assign entity_3      = active_bank[2*ENTITY_W +: ENTITY_W];
   assign entity_4      = active_bank[3*ENTITY_W +: ENTITY_W];
   assign entity_5      = active_bank[4*ENTITY_W +: ENTITY_W];
   assign entity_6      = active_bank[5*ENTITY_W +: ENTITY_W];
   assign entity_7      = active_bank[6*ENTITY_W +: ENTITY_W];
   assign entity_8_Flip = active_bank[7*ENTITY_W +: ENTITY_W];
   assign entity_9_Flip = active_bank[8*ENTITY_W +: ENTITY_W];

endmodule

// File: tb/tb_entity_loader.sv
// Scoreboard bench for entity_loader: directed scenarios followed by random
// packet traffic with free-running vblank, checked against a packet-level
// reference model of the shadow/active banks.
module tb_entity_loader;

   localparam logic [13:0] UNUSED = 14'h3C00;

   logic        clk;
   logic        reset;
   logic [7:0]  data_in;
   logic        data_valid;
   logic        data_sof;
   logic        data_ready;
   logic        vblank;
   logic [13:0] entity_1, entity_2, entity_3, entity_4, entity_5;
   logic [13:0] entity_6, entity_7, entity_8_Flip, entity_9_Flip;
   logic        frame_commit;
   logic        slot_err;

   entity_loader dut (
      .clk           (clk),
      .reset         (reset),
      .data_in       (data_in),
      .data_valid    (data_valid),
      .data_sof      (data_sof),
      .data_ready    (data_ready),
      .vblank        (vblank),
      .entity_1      (entity_1),
      .entity_2      (entity_2),
      .entity_3      (entity_3),
      .entity_4      (entity_4),
      .entity_5      (entity_5),
      .entity_6      (entity_6),
      .entity_7      (entity_7),
      .entity_8_Flip (entity_8_Flip),
      .entity_9_Flip (entity_9_Flip),
      .frame_commit  (frame_commit),
      .slot_err      (slot_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [125:0] dut_bank;
   assign dut_bank = {entity_9_Flip, entity_8_Flip, entity_7, entity_6, entity_5,
                      entity_4, entity_3, entity_2, entity_1};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int           edge_no;
      logic [125:0] bank;
   } exp_t;

   exp_t        exp_q[$];
   logic [13:0] sh_m  [9];
   logic [13:0] act_m [9];
   bit          dirty_m, rise_m, vprev_m, err_m, ready_m;
   int          stall_m;
   int          have_m;
   logic [3:0]  p_slot, p_id;
   logic [1:0]  p_or;
   bit          p_drop;
   int          edge_cnt = 0;

   function automatic logic [125:0] flat(input logic [13:0] b [9]);
      logic [125:0] f;
      for (int i = 0; i < 9; i++) f[i*14 +: 14] = b[i];
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 9; i++) begin
         sh_m[i]  = UNUSED;
         act_m[i] = UNUSED;
      end
      dirty_m = 0; rise_m = 0; vprev_m = 1; err_m = 0; ready_m = 0;
      stall_m = 0; have_m = 0; p_drop = 0;
      exp_q.delete();
   endtask

   task automatic model_edge();
      bit   commit_now;
      bit   wrote;
      exp_t e;
      logic [3:0] s;
      commit_now = rise_m && dirty_m;
      if (commit_now) begin
         e.edge_no = edge_cnt;
         e.bank    = flat(sh_m);
         exp_q.push_back(e);
         for (int i = 0; i < 9; i++) act_m[i] = sh_m[i];
      end
      wrote = 0;
      if (stall_m > 0) begin
         sh_m[9 - stall_m] = UNUSED;
         stall_m--;
         wrote = 1;
      end else if (data_valid && ready_m) begin
         if (data_sof) begin
            s = data_in[7:4];
            if (s == 4'hF) begin
               stall_m = 9;
               have_m  = 0;
            end else begin
               have_m = 1;
               p_slot = s;
               p_id   = data_in[3:0];
               p_drop = (s > 4'd8);
               if (p_drop) err_m = 1;
            end
         end else if (have_m == 1) begin
            p_or   = data_in[7:6];
            have_m = 2;
         end else if (have_m == 2) begin
            if (!p_drop) begin
               sh_m[p_slot] = {p_id, p_or, data_in};
               wrote = 1;
            end
            have_m = 0;
         end
      end
      if (wrote)           dirty_m = 1;
      else if (commit_now) dirty_m = 0;
      rise_m  = vblank && !vprev_m;
      vprev_m = vblank;
      ready_m = (stall_m == 0);
      edge_cnt++;
   endtask

   initial begin : model
      model_reset();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) model_reset();
         else        model_edge();
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         chk("active_bank", dut_bank, flat(act_m));
         chk("data_ready", data_ready, ready_m);
         chk("slot_err", slot_err, err_m);
         checks++;
         if (frame_commit) begin
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_commit actual=1 required=0 edge=%0d", edge_cnt);
            end else begin
               e = exp_q.pop_front();
               if (e.edge_no != edge_cnt - 1 || e.bank !== dut_bank) begin
                  failures++;
                  $display("FAIL commit_content actual_edge=%0d required_edge=%0d actual=%h required=%h",
                           edge_cnt - 1, e.edge_no, dut_bank, e.bank);
               end
            end
         end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            failures++;
            $display("FAIL missing_commit actual=0 required=1 edge=%0d", e.edge_no);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one byte and hold it until accepted; returns #1 after the accepting edge
   task automatic send(input logic [7:0] d, input bit s);
      bit got = 0;
      data_in = d; data_sof = s; data_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (data_ready) begin
            got = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      data_valid = 1'b0; data_sof = 1'b0;
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=not_ready required=ready byte=%h", d);
      end
   endtask

   task automatic packet(input logic [7:0] h, input logic [7:0] o, input logic [7:0] t);
      send(h, 1'b1);
      send(o, 1'b0);
      send(t, 1'b0);
   endtask

   // Blanking interval; returns #1 after the commit edge (2 edges after rise)
   task automatic vblank_rise();
      vblank = 1'b1;
      idle(2);
   endtask

   task automatic vblank_fall();
      idle(2);
      vblank = 1'b0;
      idle(2);
   endtask

   bit rand_done = 0;

   initial begin
      int cnt;
      reset = 1'b0; data_in = 8'h00; data_valid = 1'b0; data_sof = 1'b0; vblank = 1'b0;
      idle(3);
      chk("reset_entity_1", entity_1, UNUSED);
      chk("reset_entity_9", entity_9_Flip, UNUSED);
      chk("reset_ready", data_ready, 1'b0);
      chk("reset_commit", frame_commit, 1'b0);
      reset = 1'b1;
      idle(2);

      // Basic write and commit
      packet(8'h23, 8'h80, 8'h5A);
      idle(2);
      chk("basic_pre_vblank", entity_3, UNUSED);
      vblank = 1'b1;
      idle(1);
      chk("basic_fc_early", frame_commit, 1'b0);
      chk("basic_e3_early", entity_3, UNUSED);
      idle(1);
      chk("basic_fc", frame_commit, 1'b1);
      chk("basic_e3", entity_3, 14'h0E5A);
      idle(1);
      chk("basic_fc_once", frame_commit, 1'b0);
      vblank_fall();
      $display("txn basic: entity_3=%h", entity_3);

      // Resync: abandoned slot-1 packet, then a slot-0 packet
      send(8'h12, 1'b1);
      send(8'hC0, 1'b0);
      packet(8'h01, 8'h40, 8'h07);
      vblank_rise();
      chk("resync_e1", entity_1, 14'h0507);
      chk("resync_e2", entity_2, UNUSED);
      vblank_fall();
      $display("txn resync: entity_1=%h entity_2=%h", entity_1, entity_2);

      // Bad slot: dropped, sticky error, no commit
      packet(8'h9B, 8'h00, 8'h11);
      idle(1);
      chk("badslot_err", slot_err, 1'b1);
      vblank = 1'b1;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (frame_commit) cnt++;
      end
      chk("badslot_no_commit", cnt, 0);
      @(posedge clk); #1;
      vblank_fall();
      $display("txn badslot: slot_err=%b", slot_err);

      // Clear command
      packet(8'h0A, 8'h00, 8'h33);
      packet(8'h85, 8'hC0, 8'h44);
      vblank_rise();
      chk("clr_load_e1", entity_1, 14'h2833);
      chk("clr_load_e9", entity_9_Flip, 14'h1744);
      vblank_fall();
      send(8'hF0, 1'b1);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (data_ready) break;
         cnt++;
      end
      chk("clr_stall_cycles", cnt, 9);
      @(posedge clk); #1;
      vblank_rise();
      chk("clr_all_unused", dut_bank, {9{UNUSED}});
      vblank_fall();
      $display("txn clear: stall=%0d", cnt);

      // Collision: slot-4 byte 2 accepted on the commit edge
      packet(8'h47, 8'h40, 8'h21);
      vblank_rise();
      chk("coll_old_e5", entity_5, 14'h1D21);
      vblank_fall();
      packet(8'h03, 8'h00, 8'h10);
      send(8'h49, 1'b1);
      send(8'h80, 1'b0);
      vblank = 1'b1;
      idle(1);
      send(8'h99, 1'b0);
      chk("coll_fc", frame_commit, 1'b1);
      chk("coll_e1_new", entity_1, 14'h0C10);
      chk("coll_e5_kept", entity_5, 14'h1D21);
      vblank_fall();
      vblank_rise();
      chk("coll_e5_late", entity_5, 14'h2699);
      vblank_fall();
      $display("txn collision: entity_5=%h", entity_5);

      // Reset mid-packet
      send(8'h36, 1'b1);
      send(8'h80, 1'b0);
      reset = 1'b0;
      idle(2);
      chk("rst_bank", dut_bank, {9{UNUSED}});
      chk("rst_err", slot_err, 1'b0);
      chk("rst_ready", data_ready, 1'b0);
      reset = 1'b1;
      idle(2);
      packet(8'h36, 8'h80, 8'h11);
      vblank_rise();
      chk("rst_after_e4", entity_4, 14'h1A11);
      vblank_fall();
      $display("txn reset: entity_4=%h", entity_4);

      // Random traffic with independently toggling vblank
      fork
         begin
            for (int n = 0; n < 250; n++) begin
               int r;
               r = $urandom_range(0, 19);
               if (r <= 13)
                  packet({4'($urandom_range(0, 8)), 4'($urandom_range(0, 15))},
                         8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
               else if (r == 14)
                  packet({4'($urandom_range(9, 14)), 4'($urandom_range(0, 15))},
                         8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
               else if (r == 15)
                  send({4'hF, 4'($urandom_range(0, 15))}, 1'b1);
               else if (r == 16)
                  send(8'($urandom_range(0, 255)), 1'b0);
               else if (r == 17) begin
                  send({4'($urandom_range(0, 8)), 4'($urandom_range(0, 15))}, 1'b1);
                  if ($urandom_range(0, 1) == 1) send(8'($urandom_range(0, 255)), 1'b0);
               end else
                  idle($urandom_range(1, 4));
               $display("txn random %0d: kind=%0d bank=%h", n, r, dut_bank);
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               if ($urandom_range(0, 11) == 0) vblank = ~vblank;
            end
         end
      join
      vblank = 1'b0;
      idle(4);
      vblank_rise();
      vblank_fall();
      idle(4);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
